console_demux: RTL and testbench

- Host-to-console direction of the console mux: routes one serial TX line from the host to one of N_PORTS console RX lines, chosen by sel.
- Selection changes take effect only after the line has idled high (UART idle) for IDLE_CYCLES consecutive clocks, so a character is never split across two consoles.
- Unselected outputs are held at idle-high.

---
 rtl/console_demux.sv | 125 ++++++++++++
 tb/tb_console_demux.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/console_demux.sv
`default_nettype none
// ============================================================================
// Module      : console_demux
// Description : Host-to-console direction of the console mux. Routes the
//               host serial TX line to one of N_PORTS console RX lines.
//               A new selection only takes effect once the line has idled
//               high for IDLE_CYCLES clocks, so a character is never split
//               between two consoles. Unrouted outputs idle high.
// Revision    : 1.0 - initial release
// ============================================================================
module console_demux #(
    parameter int N_PORTS     = 4,
    parameter int SEL_W       = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int CNT_W       = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in,
    input  logic [SEL_W-1:0]   sel,
    output logic [N_PORTS-1:0] out,
    output logic [SEL_W-1:0]   active_sel,
    output logic               active_valid,
    output logic               switching
);

    // Saturation value of the idle counter.
    localparam logic [CNT_W-1:0] c_IDLE_MAX = CNT_W'(IDLE_CYCLES);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_active_sel;
    logic [SEL_W-1:0]   w_active_sel_nxt;
    logic               r_active_valid;
    logic               w_active_valid_nxt;
    logic [CNT_W-1:0]   r_idle_cnt;
    logic [N_PORTS-1:0] r_out;
    logic [N_PORTS-1:0] w_route;
    logic               w_sel_differs;
    logic               w_sel_in_range;
    logic               w_line_idle;

    // Full-width compare: out-of-range codes are distinct targets too.
    assign w_sel_differs  = (sel != r_active_sel);
    // Zero-extend before comparing so any N_PORTS/SEL_W pairing is safe.
    assign w_sel_in_range = ({{(32-SEL_W){1'b0}}, sel} < 32'(N_PORTS));
    // Commit is only allowed at a character boundary: long idle and still high.
    assign w_line_idle    = (r_idle_cnt == c_IDLE_MAX) && in;

    // Count consecutive idle-high clocks, saturating so it never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if (!in) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != c_IDLE_MAX) begin
            r_idle_cnt <= r_idle_cnt + CNT_W'(1);
        end
    end

    // One-hot routing mask decoded from the registered selection.
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_route
        assign w_route[gi] = r_active_valid && (r_active_sel == SEL_W'(gi));
    end

    // Registered data path: routed port copies the line, all others idle high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out <= '1;
        end else begin
            r_out <= ~w_route | {N_PORTS{in}};
        end
    end

    // State and active-selection registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_RUN;
            r_active_sel   <= '0;
            r_active_valid <= 1'b1;
        end else begin
            r_state        <= w_state_nxt;
            r_active_sel   <= w_active_sel_nxt;
            r_active_valid <= w_active_valid_nxt;
        end
    end

    // Next-state logic: request on mismatch, cancel on match, commit when idle.
    always_comb begin
        w_state_nxt        = r_state;
        w_active_sel_nxt   = r_active_sel;
        w_active_valid_nxt = r_active_valid;
        case (r_state)
            ST_RUN: begin
                if (w_sel_differs) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!w_sel_differs) begin
                    w_state_nxt = ST_RUN;
                end else if (w_line_idle) begin
                    w_state_nxt        = ST_RUN;
                    w_active_sel_nxt   = sel;
                    w_active_valid_nxt = w_sel_in_range;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign out          = r_out;
    assign active_sel   = r_active_sel;
    assign active_valid = r_active_valid;
    assign switching    = (r_state == ST_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_console_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_console_demux
// Description : Self-checking bench for console_demux: a cycle-by-cycle
//               vector table followed by hand-written frame, break and
//               reset-during-wait sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_console_demux;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic [3:0] sel;
    logic [3:0] out;
    logic [3:0] active_sel;
    logic       active_valid;
    logic       switching;

    int tests;
    int fails;

    console_demux #(
        .N_PORTS    (4),
        .SEL_W      (4),
        .IDLE_CYCLES(16),
        .CNT_W      (5)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (din),
        .sel         (sel),
        .out         (out),
        .active_sel  (active_sel),
        .active_valid(active_valid),
        .switching   (switching)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       in;
        logic [3:0] sel;
        int         reps;
        logic [3:0] e_out;
        logic [3:0] e_as;
        logic       e_v;
        logic       e_sw;
    } vec_t;

    vec_t vt[$];

    // Drive inputs at the falling edge, then sample just after the rising edge.
    task automatic apply(input logic r, input logic i, input logic [3:0] s);
        @(negedge clk);
        rst_n = r;
        din   = i;
        sel   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] eo, input logic [3:0] ea,
                         input logic ev, input logic es);
        tests++;
        if (out !== eo || active_sel !== ea || active_valid !== ev || switching !== es) begin
            fails++;
            $display("FAIL %s: got out=%b active_sel=%0d valid=%b switching=%b, want out=%b active_sel=%0d valid=%b switching=%b",
                     name, out, active_sel, active_valid, switching, eo, ea, ev, es);
        end
    endtask

    task automatic step_chk(input string name, input logic i, input logic [3:0] s,
                            input logic [3:0] eo, input logic [3:0] ea,
                            input logic ev, input logic es);
        apply(1'b1, i, s);
        check(name, eo, ea, ev, es);
    endtask

    logic [9:0] frame;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        din   = 1'b1;
        sel   = 4'd0;

        //                rst   in   sel  reps out      as  v     sw
        vt.push_back('{1'b0, 1'b1, 4'd0, 1,  4'b1111, 4'd0, 1'b1, 1'b0}); // reset
        vt.push_back('{1'b1, 1'b1, 4'd0, 1,  4'b1111, 4'd0, 1'b1, 1'b0});
        vt.push_back('{1'b1, 1'b0, 4'd0, 1,  4'b1110, 4'd0, 1'b1, 1'b0}); // port0 follows
        vt.push_back('{1'b1, 1'b1, 4'd0, 1,  4'b1111, 4'd0, 1'b1, 1'b0});
        vt.push_back('{1'b1, 1'b1, 4'd0, 1,  4'b1111, 4'd0, 1'b1, 1'b0});
        vt.push_back('{1'b1, 1'b0, 4'd0, 1,  4'b1110, 4'd0, 1'b1, 1'b0});
        vt.push_back('{1'b1, 1'b1, 4'd0, 1,  4'b1111, 4'd0, 1'b1, 1'b0});
        vt.push_back('{1'b1, 1'b1, 4'd0, 40, 4'b1111, 4'd0, 1'b1, 1'b0}); // counter saturates
        vt.push_back('{1'b1, 1'b1, 4'd2, 1,  4'b1111, 4'd0, 1'b1, 1'b1}); // enter wait
        vt.push_back('{1'b1, 1'b1, 4'd2, 1,  4'b1111, 4'd2, 1'b1, 1'b0}); // commit next edge
        vt.push_back('{1'b1, 1'b0, 4'd2, 1,  4'b1011, 4'd2, 1'b1, 1'b0}); // port2 routed
        vt.push_back('{1'b1, 1'b1, 4'd2, 1,  4'b1111, 4'd2, 1'b1, 1'b0});
        vt.push_back('{1'b1, 1'b0, 4'd2, 1,  4'b1011, 4'd2, 1'b1, 1'b0});
        vt.push_back('{1'b1, 1'b1, 4'd3, 1,  4'b1111, 4'd2, 1'b1, 1'b1}); // request 3
        vt.push_back('{1'b1, 1'b0, 4'd1, 1,  4'b1011, 4'd2, 1'b1, 1'b1}); // retarget 1
        vt.push_back('{1'b1, 1'b1, 4'd2, 1,  4'b1111, 4'd2, 1'b1, 1'b0}); // cancel
        vt.push_back('{1'b1, 1'b1, 4'd2, 20, 4'b1111, 4'd2, 1'b1, 1'b0});
        vt.push_back('{1'b1, 1'b1, 4'd7, 1,  4'b1111, 4'd2, 1'b1, 1'b1}); // out of range
        vt.push_back('{1'b1, 1'b1, 4'd7, 1,  4'b1111, 4'd7, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b0, 4'd7, 1,  4'b1111, 4'd7, 1'b0, 1'b0}); // nothing routed
        vt.push_back('{1'b1, 1'b1, 4'd7, 16, 4'b1111, 4'd7, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b1, 4'd5, 1,  4'b1111, 4'd7, 1'b0, 1'b1}); // 5 differs from 7
        vt.push_back('{1'b1, 1'b1, 4'd5, 1,  4'b1111, 4'd5, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b1, 4'd1, 1,  4'b1111, 4'd5, 1'b0, 1'b1});
        vt.push_back('{1'b1, 1'b1, 4'd1, 1,  4'b1111, 4'd1, 1'b1, 1'b0});
        vt.push_back('{1'b1, 1'b0, 4'd1, 1,  4'b1101, 4'd1, 1'b1, 1'b0}); // port1 routed
        vt.push_back('{1'b1, 1'b1, 4'd1, 1,  4'b1111, 4'd1, 1'b1, 1'b0});
        vt.push_back('{1'b1, 1'b1, 4'd3, 1,  4'b1111, 4'd1, 1'b1, 1'b1});
        vt.push_back('{1'b1, 1'b1, 4'd3, 13, 4'b1111, 4'd1, 1'b1, 1'b1}); // idle count 15
        vt.push_back('{1'b1, 1'b0, 4'd3, 1,  4'b1101, 4'd1, 1'b1, 1'b1}); // low pulse restarts
        vt.push_back('{1'b1, 1'b1, 4'd3, 16, 4'b1111, 4'd1, 1'b1, 1'b1}); // still waiting at 15
        vt.push_back('{1'b1, 1'b1, 4'd3, 1,  4'b1111, 4'd3, 1'b1, 1'b0}); // commit at 16
        vt.push_back('{1'b1, 1'b0, 4'd3, 1,  4'b0111, 4'd3, 1'b1, 1'b0});

        for (int i = 0; i < vt.size(); i++) begin
            for (int r = 0; r < vt[i].reps; r++) begin
                apply(vt[i].rst_n, vt[i].in, vt[i].sel);
                check($sformatf("vec%0d.%0d", i, r), vt[i].e_out, vt[i].e_as, vt[i].e_v, vt[i].e_sw);
            end
        end

        // Mid-frame switch: 0x55 frame, LSB first, start/stop bits framing it.
        for (int k = 0; k < 20; k++)
            step_chk($sformatf("preidle%0d", k), 1'b1, 4'd3, 4'b1111, 4'd3, 1'b1, 1'b0);
        frame = 10'b1_0101_0101_0;
        for (int b = 0; b < 10; b++) begin
            step_chk($sformatf("frame%0d", b), frame[b], (b >= 3) ? 4'd2 : 4'd3,
                     {frame[b], 3'b111}, 4'd3, 1'b1, (b >= 3) ? 1'b1 : 1'b0);
        end
        for (int k = 1; k <= 15; k++)
            step_chk($sformatf("postframe%0d", k), 1'b1, 4'd2, 4'b1111, 4'd3, 1'b1, 1'b1);
        step_chk("frame_commit", 1'b1, 4'd2, 4'b1111, 4'd2, 1'b1, 1'b0);
        step_chk("frame_route", 1'b0, 4'd2, 4'b1011, 4'd2, 1'b1, 1'b0);

        // Break condition holds the switch off indefinitely.
        for (int k = 0; k < 40; k++)
            step_chk($sformatf("break%0d", k), 1'b0, 4'd0, 4'b1011, 4'd2, 1'b1, 1'b1);
        for (int k = 0; k < 16; k++)
            step_chk($sformatf("brkidle%0d", k), 1'b1, 4'd0, 4'b1111, 4'd2, 1'b1, 1'b1);
        step_chk("brk_commit", 1'b1, 4'd0, 4'b1111, 4'd0, 1'b1, 1'b0);
        step_chk("brk_route", 1'b0, 4'd0, 4'b1110, 4'd0, 1'b1, 1'b0);

        // Reset while waiting with port 2 active discards the request.
        for (int k = 0; k < 16; k++)
            step_chk($sformatf("to2_%0d", k), 1'b1, 4'd2, 4'b1111, 4'd0, 1'b1, 1'b1);
        step_chk("to2_commit", 1'b1, 4'd2, 4'b1111, 4'd2, 1'b1, 1'b0);
        step_chk("wait3", 1'b1, 4'd3, 4'b1111, 4'd2, 1'b1, 1'b1);
        apply(1'b0, 1'b1, 4'd3);
        check("rst_in_wait", 4'b1111, 4'd0, 1'b1, 1'b0);
        step_chk("post_rst", 1'b1, 4'd0, 4'b1111, 4'd0, 1'b1, 1'b0);
        step_chk("post_rst_req", 1'b1, 4'd1, 4'b1111, 4'd0, 1'b1, 1'b1);
        step_chk("idle_cnt_cleared", 1'b1, 4'd1, 4'b1111, 4'd0, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
